// File: rtl/sakebi_fifo_wr_arbiter.sv
// rtl/sakebi_fifo_wr_arbiter.sv - packet-granular round-robin arbiter sharing one FIFO write port
// Grants one requester per packet; packets longer than MAX_BEATS are split and re-arbitrated.
module sakebi_fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BEATS  = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rstn,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ-1:0]            i_req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic                          i_fifo_wr_ready,
   output logic                          o_fifo_wr_en,
   output logic [DATA_WIDTH:0]           o_fifo_wr_data,
   output logic [NUM_REQ-1:0]            o_grant,
   output logic                          o_busy,
   output logic                          o_trunc
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BEATS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W:0]   NUM_W    = (IDX_W+1)'(NUM_REQ);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] last_owner_q, last_owner_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             trunc_q, trunc_d;

   logic                  busy;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  trunc_now;
   logic                  beat_acc;
   logic [IDX_W-1:0]      pick_idx;
   logic [IDX_W:0]        cand;

   assign busy = (state_q == ST_BUSY);

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      o_grant   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IDX_W'(i)) begin
            sel_valid  = i_req_valid[i];
            sel_last   = i_req_last[i];
            sel_data   = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            o_grant[i] = busy;
         end
      end
   end

   // Scan downward so the nearest valid requester after the last owner wins.
   always_comb begin
      pick_idx = '0;
      cand     = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = {1'b0, last_owner_q} + (IDX_W+1)'(k);
         if (cand >= NUM_W) begin
            cand = cand - NUM_W;
         end
         if (i_req_valid[cand[IDX_W-1:0]]) begin
            pick_idx = cand[IDX_W-1:0];
         end
      end
   end

   assign trunc_now      = busy & (count_q == CNT_LAST) & ~sel_last;
   assign o_req_ready    = o_grant & {NUM_REQ{i_fifo_wr_ready}};
   assign o_fifo_wr_en   = busy & sel_valid & i_fifo_wr_ready;
   assign o_fifo_wr_data = {sel_last | trunc_now, sel_data};
   assign o_busy         = busy;
   assign o_trunc        = trunc_q;
   assign beat_acc       = o_fifo_wr_en;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      count_d      = count_q;
      trunc_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|i_req_valid) begin
               state_d = ST_BUSY;
               owner_d = pick_idx;
               count_d = '0;
            end
         end
         ST_BUSY: begin
            if (beat_acc) begin
               count_d = count_q + 1'b1;
               if (sel_last | trunc_now) begin
                  state_d      = ST_IDLE;
                  last_owner_d = owner_q;
                  trunc_d      = trunc_now;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         last_owner_q <= IDX_LAST;
         count_q      <= '0;
         trunc_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         count_q      <= count_d;
         trunc_q      <= trunc_d;
      end
   end

endmodule

// File: doc/sakebi_fifo_wr_arbiter.md
# sakebi_fifo_wr_arbiter

Packet-granular round-robin arbiter that shares the write port of one `sakebi_async_fifo` among `NUM_REQ` requesters in the FIFO write-clock domain. Each requester streams beats with valid/ready/last. The arbiter grants one requester per packet, muxes its beats onto the FIFO write interface, and appends the `last` flag as the FIFO data MSB. Packets longer than `MAX_BEATS` are split by force, so no requester can monopolise the FIFO.

## Interface

- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 8: payload width per beat.
- `MAX_BEATS`, 16: maximum beats per grant, ≥2.

- `i_clk` in 1: clock; same clock as the FIFO `i_wr_clk`.
- `i_rstn` in 1: reset, asynchronous assert, active-low.
- `i_req_valid` in `NUM_REQ`: per-requester beat valid.
- `i_req_last` in `NUM_REQ`: per-requester end-of-packet, qualified by valid.
- `i_req_data` in `NUM_REQ*DATA_WIDTH`: requester i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `o_req_ready` out `NUM_REQ`: per-requester beat accept.
- `i_fifo_wr_ready` in 1: from FIFO `o_wr_ready` (not full).
- `o_fifo_wr_en` out 1: FIFO write strobe.
- `o_fifo_wr_data` out `DATA_WIDTH+1`: `{last, data}` to FIFO; the FIFO instance uses `DATA_WIDTH+1`.
- `o_grant` out `NUM_REQ`: one-hot current owner, all zero when idle.
- `o_busy` out 1: high while a grant is held.
- `o_trunc` out 1: one-cycle pulse after a forced packet split.

## Operation

- FSM has two states, IDLE and BUSY. Reset puts it in IDLE.
- IDLE:
  - If any `i_req_valid` is high, select the first valid index searching from `r_last_owner+1` upward, wrapping modulo `NUM_REQ`.
  - On the next edge, load the owner, clear the beat counter, and go to BUSY.
  - No beats are accepted in IDLE.
- BUSY:
  - `o_req_ready[i] = (owner==i) & i_fifo_wr_ready`. The other ready bits are 0.
  - `o_fifo_wr_en = i_req_valid[owner] & i_fifo_wr_ready`.
  - `o_fifo_wr_data = {i_req_last[owner] | trunc_now, i_req_data[owner]}`.
  - A beat is accepted when `o_fifo_wr_en` is high.
- Ownership holds through bubbles, i.e. owner valid low or FIFO full. There is no timeout.
- Beat counter:
  - Width is `$clog2(MAX_BEATS)`; it increments per accepted beat.
  - `trunc_now = (count == MAX_BEATS-1) & ~i_req_last[owner]`.
- Packet end is an accepted beat with `i_req_last[owner]` set or `trunc_now` set. On packet end:
  - FSM goes to IDLE.
  - `r_last_owner` is set to the owner.
  - `o_trunc` is registered to 1 for one cycle if the end was caused by `trunc_now`.
- After a truncation, the requester's remaining beats re-arbitrate as a new packet at the lowest round-robin priority.
- `o_grant` and `o_busy` are decoded from the FSM/owner registers, not from inputs.
- Reset values:
  - `o_grant=0`, `o_busy=0`, `o_trunc=0`, `o_req_ready=0`, `o_fifo_wr_en=0`.
  - `r_last_owner = NUM_REQ-1`, so requester 0 wins first.
  - `o_fifo_wr_data` is don't-care while `o_fifo_wr_en` is 0.
- Reset mid-packet aborts immediately. The FIFO holds a packet with no last beat, so the FIFO and consumer must share this reset.
- Requester valid deasserted mid-packet, or a changed unselected requester, has no effect on the grant.

## Timing

- Arbitration latency:
  - Valid in IDLE cycle 0 → `o_grant`/`o_busy` high in cycle 1.
  - First beat is accepted in cycle 1 if the FIFO is ready.
- Packet-end beat in cycle k → IDLE in cycle k+1 (`o_grant=0`, arbitrates) → next owner in cycle k+2. This is a one-bubble cycle between packets.
- `o_trunc` is high in cycle k+1 when the end at cycle k was forced.
- Ready and write-enable are combinational from `i_fifo_wr_ready`/`i_req_valid`.
  - There are no registers in the data path; write latency is 0 cycles.
  - Combinational paths from requester inputs to `o_req_ready` are forbidden; ready depends only on state and `i_fifo_wr_ready`.
- Full throughput within a packet is 1 beat/cycle.

## Test plan

- **Reset/idle.** Hold `i_rstn=0`, then release with all valid low → all outputs 0 and FSM stays IDLE for 10 cycles.
- **Single packet.** Req 2 sends 3 beats 0xA1, 0xA2, 0xA3 with last on the third; FIFO always ready → `o_grant=4'b0100` from cycle 1. FIFO receives 0x0A1, 0x0A2, 0x1A3. `o_grant=0` in the cycle after.
- **Round-robin.** Reqs 0, 1, 3 each send continuous 2-beat packets → grant order 0, 1, 3, 0, 1, 3, with exactly one idle cycle between packets.
- **Backpressure.** `i_fifo_wr_ready` drops for 5 cycles mid-packet of req 1 → `o_fifo_wr_en=0` and `o_req_ready=0` for those cycles. Grant is held, no beat is lost or duplicated, and order is preserved.
- **Truncation.** `MAX_BEATS=16`, req 0 sends 20 beats with last on beat 20 while req 1 is also valid:
  - Beat 16 is written with MSB=1 and `o_trunc` pulses in the next cycle.
  - Req 1 is granted next.
  - Req 0's remaining 4 beats follow as a separate packet.
- **Reset mid-packet.** Assert `i_rstn=0` asynchronously during beat 2 of req 3 → `o_grant`, `o_fifo_wr_en`, and `o_req_ready` are 0 immediately. After release, req 0 wins first.
